// File: rtl/fault_injector_stream_if.sv
// Valid/ready stream bundle around the fault injector: upstream codeword in,
// faulted codeword plus its flip mask out.
interface fault_injector_stream_if #(
  parameter int DATA_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_err_mask;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_mask
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_mask
  );
endinterface

// File: rtl/fault_injector_stream.sv
// Streaming codeword fault injector: one register stage between encoder and decoder,
// flipping bits on a synchronised trigger or at an LFSR-driven random rate.
module fault_injector_stream #(
  parameter int          DATA_W = 7,
  localparam int         IDX_W  = $clog2(DATA_W),
  parameter int          RATE_W = 8,
  parameter logic [15:0] TAPS   = 16'hB400,
  parameter int          CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fault_injector_stream_if.slave bus,
  input  logic [1:0]           mode,
  input  logic [IDX_W-1:0]     bit_sel,
  input  logic [IDX_W-1:0]     bit_sel2,
  input  logic [RATE_W-1:0]    rate,
  input  logic                 trigger,
  input  logic                 seed_load,
  input  logic [15:0]          seed,
  output logic [CNT_W-1:0]     inj_count
);

  localparam logic [15:0]      LFSR_INIT = 16'hACE1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [DATA_W-1:0] out_mask_q,  out_mask_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              armed_q,     armed_d;
  logic [2:0]        sync_q,      sync_d;
  logic [15:0]       lfsr_q,      lfsr_d;

  logic              accept;
  logic              trig_edge;
  logic [DATA_W-1:0] inj_mask;

  // Indices past the top of the codeword select nothing.
  function automatic logic [DATA_W-1:0] bit_flip(input logic [IDX_W-1:0] idx);
    bit_flip = '0;
    if (int'(idx) < DATA_W) bit_flip[idx] = 1'b1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [15:0] seed_value(input logic [15:0] s);
    seed_value = (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  assign bus.in_ready     = !out_valid_q || bus.out_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_err_mask = out_mask_q;
  assign inj_count        = cnt_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign trig_edge = sync_q[1] && !sync_q[2];

  always_comb begin
    inj_mask = '0;
    case (mode)
      2'd1: if (armed_q) inj_mask = bit_flip(bit_sel);
      2'd2: if (armed_q) inj_mask = bit_flip(bit_sel) | bit_flip(bit_sel2);
      2'd3: if (lfsr_q[RATE_W-1:0] < rate) inj_mask = bit_flip(lfsr_q[15 -: IDX_W]);
      default: inj_mask = '0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    lfsr_d      = lfsr_q;
    sync_d      = {sync_q[1:0], trigger};

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data ^ inj_mask;
      out_mask_d  = inj_mask;
      if ((inj_mask != '0) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // A fresh trigger edge beats a one-shot consuming the arm in the same cycle.
    if (trig_edge) armed_d = 1'b1;
    else if (accept && (mode == 2'd1 || mode == 2'd2)) armed_d = 1'b0;

    // Masks always use the pre-advance LFSR value; a seed load overrides the step.
    if (seed_load) lfsr_d = seed_value(seed);
    else if (accept) lfsr_d = lfsr_step(lfsr_q);
  end

  // Output data is cleared on reset too so a reset leaves a clean, zero bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      sync_q      <= '0;
      lfsr_q      <= LFSR_INIT;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      sync_q      <= sync_d;
      lfsr_q      <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_fault_injector_stream.sv
// Randomised bench for fault_injector_stream: a transaction-level model predicts every
// output word, flip mask and count; directed literals pin both model and DUT.
module tb_fault_injector_stream;
  localparam int DW      = 7;
  localparam int IW      = 3;
  localparam int RW      = 8;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fault_injector_stream_if #(.DATA_W(DW)) bus ();

  logic [1:0]    mode;
  logic [IW-1:0] bit_sel, bit_sel2;
  logic [RW-1:0] rate;
  logic          trigger, seed_load;
  logic [15:0]   seed;
  logic [CW-1:0] inj_count;

  fault_injector_stream #(.DATA_W(DW), .RATE_W(RW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mode      (mode),
    .bit_sel   (bit_sel),
    .bit_sel2  (bit_sel2),
    .rate      (rate),
    .trigger   (trigger),
    .seed_load (seed_load),
    .seed      (seed),
    .inj_count (inj_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the block must present, advanced once per clock.
  bit        m_valid = 1'b0;
  bit [6:0]  m_data  = '0;
  bit [6:0]  m_mask  = '0;
  int        m_cnt   = 0;
  bit [15:0] m_lfsr  = 16'hACE1;
  bit        m_armed = 1'b0;
  bit        m_prev  = 1'b0;
  int        cyc     = 0;
  int        arm_q[$];

  function automatic bit [6:0] flip(input int idx);
    return (idx < DW) ? 7'(1 << idx) : 7'd0;
  endfunction

  always @(posedge clk) begin : model
    bit       acc, edge_now;
    bit [6:0] mk;
    int       r, k;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_mask = '0; m_cnt = 0;
      m_lfsr = 16'hACE1; m_armed = 1'b0; m_prev = 1'b0;
      arm_q.delete();
    end else begin
      acc = bus.in_valid && (!m_valid || bus.out_ready);
      mk  = '0;
      if (acc) begin
        case (mode)
          2'd1: if (m_armed) mk = flip(int'(bit_sel));
          2'd2: if (m_armed) mk = flip(int'(bit_sel)) | flip(int'(bit_sel2));
          2'd3: begin
            r = int'(m_lfsr) % 256;
            k = int'(m_lfsr) / 8192;
            if (r < int'(rate)) mk = flip(k);
          end
          default: mk = '0;
        endcase
        m_valid = 1'b1;
        m_data  = bus.in_data ^ mk;
        m_mask  = mk;
        if (mk != 0 && m_cnt < CNT_MAX) m_cnt++;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
      // A trigger first seen high at clock N arms the block at clock N+2.
      edge_now = (arm_q.size() > 0) && (arm_q[0] == cyc);
      if (edge_now) void'(arm_q.pop_front());
      if (edge_now) m_armed = 1'b1;
      else if (acc && (mode == 2'd1 || mode == 2'd2)) m_armed = 1'b0;
      if (seed_load) m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
      else if (acc) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      if (trigger && !m_prev) arm_q.push_back(cyc + 2);
      m_prev = trigger;
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_err_mask", bus.out_err_mask, m_mask);
    end
    chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
    chk("inj_count", inj_count, m_cnt);
  end

  bit rnd_ready = 1'b0;

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [6:0] d);
    int n;
    bit ok;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ok = bus.in_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: in_ready stayed %0b, expected 1", bus.in_ready);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    mode = 2'd0; bit_sel = '0; bit_sel2 = '0; rate = '0;
    trigger = 1'b0; seed_load = 1'b0; seed = '0;
    #1 rst = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_mask", bus.out_err_mask, 0);
    chk("rst_count", inj_count, 0);
    rst = 1'b0;
    tick();

    // Pass-through.
    mode = 2'd0;
    send(7'h55);
    chk("pass_valid", bus.out_valid, 1);
    chk("pass_data", bus.out_data, 7'h55);
    chk("pass_mask", bus.out_err_mask, 0);
    chk("pass_count", inj_count, 0);

    // One-shot single flip, consumed by the first word only.
    mode = 2'd1; bit_sel = 3'd2;
    pulse_trigger();
    send(7'h00);
    chk("single_data", bus.out_data, 7'h04);
    chk("single_mask", bus.out_err_mask, 7'h04);
    send(7'h00);
    chk("single_second_data", bus.out_data, 7'h00);
    chk("single_count", inj_count, 1);

    // One-shot double flip, then coincident indices collapse to one flip.
    mode = 2'd2; bit_sel = 3'd0; bit_sel2 = 3'd6;
    pulse_trigger();
    send(7'h7F);
    chk("double_data", bus.out_data, 7'h3E);
    bit_sel = 3'd3; bit_sel2 = 3'd3;
    pulse_trigger();
    send(7'h7F);
    chk("double_same_data", bus.out_data, 7'h77);
    chk("double_same_mask", bus.out_err_mask, 7'h08);
    chk("double_count", inj_count, 3);

    // Out-of-range index contributes nothing.
    mode = 2'd1; bit_sel = 3'd7;
    pulse_trigger();
    send(7'h00);
    chk("oob_data", bus.out_data, 7'h00);
    chk("oob_count", inj_count, 3);

    // Backpressure: held word stays put, controls change underneath it.
    mode = 2'd0;
    send(7'h11);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 7'h22;
    mode = 2'd1; bit_sel = 3'd4;
    #1;
    repeat (3) begin
      chk("stall_in_ready", bus.in_ready, 0);
      tick();
      chk("stall_data", bus.out_data, 7'h11);
    end
    mode = 2'd0;
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("release_data", bus.out_data, 7'h22);

    // Random mode: zero seed maps to 1, zero rate never flips.
    mode = 2'd3; seed = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("model_seed_zero", m_lfsr, 16'h0001);
    rate = 8'h00;
    rnd_ready = 1'b1;
    repeat (200) send(7'($urandom));
    chk("rate0_count", inj_count, 3);

    rate = 8'h80;
    repeat (1000) begin
      send(7'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Mixed modes, triggers and reseeds.
    repeat (300) begin
      mode      = 2'($urandom);
      bit_sel   = 3'($urandom);
      bit_sel2  = 3'($urandom);
      rate      = 8'($urandom);
      trigger   = ($urandom_range(0, 3) == 0);
      seed_load = ($urandom_range(0, 15) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      send(7'($urandom));
      seed_load = 1'b0;
    end
    trigger = 1'b0;
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();

    // Reset with a stalled word and a pending arm.
    mode = 2'd1; bit_sel = 3'd1;
    pulse_trigger();
    mode = 2'd0;
    send(7'h2A);
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_count", inj_count, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    // lfsr=ACE1: r=0xE1 < 0xFF, k=5 -> flip bit 5.
    mode = 2'd3; rate = 8'hFF;
    send(7'h00);
    chk("post_rst_data", bus.out_data, 7'h20);
    chk("post_rst_mask", bus.out_err_mask, 7'h20);
    chk("model_lfsr_step", m_lfsr, 16'hE270);
    mode = 2'd1;
    send(7'h00);
    chk("arm_lost_data", bus.out_data, 7'h00);
    chk("post_rst_count", inj_count, 1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
